// File: rtl/ifetch_pkg.sv
// Shared definitions for the instruction fetch block: default word width,
// fetch FSM state encodings and the NOP instruction word.
package ifetch_pkg;

  localparam int DEF_DATA_W = 16;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_WAIT = 2'b01,
    S_HOLD = 2'b10
  } state_e;

  localparam logic [15:0] NOP = 16'h0000;

endpackage

// File: rtl/ifetch_wdt.sv
// Fetch wait-cycle watchdog: saturating counter of un-acked WAIT cycles
// with a sticky timeout flag that only reset clears.
module ifetch_wdt #(
  parameter int TMO_CYC = 15
) (
  input  logic clock,
  input  logic n_rst,
  input  logic clr,
  input  logic en,
  output logic tmo
);

  localparam int CNT_W = $clog2(TMO_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TMO_CYC);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic [CNT_W-1:0] cnt_r;
  logic             tmo_r;

  // Wait counter and sticky timeout flag
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      cnt_r <= {CNT_W{1'b0}};
      tmo_r <= 1'b0;
    end else begin
      if (clr) begin
        cnt_r <= {CNT_W{1'b0}};
      end else if (en && (cnt_r != CNT_MAX)) begin
        cnt_r <= cnt_r + CNT_ONE;
      end else begin
        cnt_r <= cnt_r;
      end
      // Flag rises on the same edge the counter reaches its limit
      if (!clr && en && (cnt_r == (CNT_MAX - CNT_ONE))) begin
        tmo_r <= 1'b1;
      end else begin
        tmo_r <= tmo_r;
      end
    end
  end

  assign tmo = tmo_r;

endmodule

// File: rtl/ifetch.sv
// Instruction fetch stage: IDLE/WAIT/HOLD handshake between the pc block,
// instruction memory and the downstream consumer, with flush and timeout.
module ifetch
  import ifetch_pkg::*;
#(
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TMO_CYC = 15
) (
  input  logic              clock,
  input  logic              n_rst,
  input  logic [DATA_W-1:0] pc_in,
  input  logic              stall,
  input  logic              flush,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [DATA_W-1:0] inst_out,
  output logic [DATA_W-1:0] pc_out,
  output logic              inst_valid,
  output logic              pc_adv,
  output logic              tmo
);

  localparam logic [DATA_W-1:0] NOP_W = DATA_W'(NOP);

  state_e            state_r, state_s;
  logic              req_r, req_s;
  logic [DATA_W-1:0] addr_r, addr_s;
  logic [DATA_W-1:0] ir_r, ir_s;
  logic [DATA_W-1:0] pcq_r, pcq_s;
  logic              valid_r, valid_s;
  logic              drop_r, drop_s;
  logic              pc_adv_s;
  logic              wdt_clr_s;
  logic              wdt_en_s;

  // State and datapath registers
  always_ff @(posedge clock or negedge n_rst) begin
    if (!n_rst) begin
      state_r <= S_IDLE;
      req_r   <= 1'b0;
      addr_r  <= {DATA_W{1'b0}};
      ir_r    <= NOP_W;
      pcq_r   <= {DATA_W{1'b0}};
      valid_r <= 1'b0;
      drop_r  <= 1'b0;
    end else begin
      state_r <= state_s;
      req_r   <= req_s;
      addr_r  <= addr_s;
      ir_r    <= ir_s;
      pcq_r   <= pcq_s;
      valid_r <= valid_s;
      drop_r  <= drop_s;
    end
  end

  // Next-state and next-value decode
  always_comb begin
    state_s  = state_r;
    req_s    = req_r;
    addr_s   = addr_r;
    ir_s     = ir_r;
    pcq_s    = pcq_r;
    valid_s  = valid_r;
    drop_s   = drop_r;
    pc_adv_s = 1'b0;
    case (state_r)
      S_IDLE: begin
        addr_s  = pc_in;
        req_s   = 1'b1;
        drop_s  = 1'b0;
        state_s = S_WAIT;
      end
      S_WAIT: begin
        if (imem_ack) begin
          req_s = 1'b0;
          // A pending or simultaneous flush discards the returning word
          if (drop_r || flush) begin
            drop_s  = 1'b0;
            state_s = S_IDLE;
          end else begin
            ir_s    = imem_rdata;
            pcq_s   = addr_r;
            valid_s = 1'b1;
            state_s = S_HOLD;
          end
        end else if (flush) begin
          drop_s = 1'b1;
        end else begin
          drop_s = drop_r;
        end
      end
      S_HOLD: begin
        if (flush) begin
          valid_s = 1'b0;
          state_s = S_IDLE;
        end else if (!stall) begin
          pc_adv_s = 1'b1;
          valid_s  = 1'b0;
          state_s  = S_IDLE;
        end else begin
          state_s = S_HOLD;
        end
      end
      default: begin
        req_s   = 1'b0;
        valid_s = 1'b0;
        drop_s  = 1'b0;
        state_s = S_IDLE;
      end
    endcase
  end

  // Counter is parked at zero in IDLE so it starts clean on every WAIT entry
  assign wdt_clr_s = (state_r == S_IDLE);
  assign wdt_en_s  = (state_r == S_WAIT) && !imem_ack;

  ifetch_wdt #(
    .TMO_CYC (TMO_CYC)
  ) u_wdt (
    .clock (clock),
    .n_rst (n_rst),
    .clr   (wdt_clr_s),
    .en    (wdt_en_s),
    .tmo   (tmo)
  );

  assign imem_req   = req_r;
  assign imem_addr  = addr_r;
  assign inst_out   = ir_r;
  assign pc_out     = pcq_r;
  assign inst_valid = valid_r;
  // Decoded in the accepting HOLD cycle so the pc block has advanced
  // before the following IDLE samples pc_in.
  assign pc_adv     = pc_adv_s;

endmodule

// File: tb/tb_ifetch.sv
// Directed self-checking bench for ifetch: reset, zero-wait stream, delayed
// ack, stall, flush cases, timeout and mid-request reset.
module tb_ifetch;

  logic        clock;
  logic        n_rst;
  logic [15:0] pc_in;
  logic        stall;
  logic        flush;
  logic        imem_req;
  logic [15:0] imem_addr;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic [15:0] inst_out;
  logic [15:0] pc_out;
  logic        inst_valid;
  logic        pc_adv;
  logic        tmo;

  int n_cmp = 0;
  int n_err = 0;

  ifetch #(.DATA_W(16), .TMO_CYC(15)) dut (
    .clock      (clock),
    .n_rst      (n_rst),
    .pc_in      (pc_in),
    .stall      (stall),
    .flush      (flush),
    .imem_req   (imem_req),
    .imem_addr  (imem_addr),
    .imem_ack   (imem_ack),
    .imem_rdata (imem_rdata),
    .inst_out   (inst_out),
    .pc_out     (pc_out),
    .inst_valid (inst_valid),
    .pc_adv     (pc_adv),
    .tmo        (tmo)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic tick;
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset;
    n_rst = 1'b0; pc_in = 16'h0000; stall = 1'b0; flush = 1'b0;
    imem_ack = 1'b0; imem_rdata = 16'h0000;
    #2;
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL rst_req: got %h want 0", imem_req); end
    n_cmp++; if (imem_addr !== 16'h0000) begin n_err++; $display("FAIL rst_addr: got %h want 0000", imem_addr); end
    n_cmp++; if (inst_out !== 16'h0000) begin n_err++; $display("FAIL rst_inst: got %h want 0000", inst_out); end
    n_cmp++; if (pc_out !== 16'h0000) begin n_err++; $display("FAIL rst_pc: got %h want 0000", pc_out); end
    n_cmp++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL rst_valid: got %h want 0", inst_valid); end
    n_cmp++; if (pc_adv !== 1'b0) begin n_err++; $display("FAIL rst_adv: got %h want 0", pc_adv); end
    n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("FAIL rst_tmo: got %h want 0", tmo); end
    tick();
    n_rst = 1'b1;
  endtask

  task automatic test_zero_wait;
    int adv_cnt;
    adv_cnt = 0;
    pc_in = 16'h0000;
    for (int k = 0; k < 4; k++) begin
      tick();
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'(k)) begin n_err++; $display("FAIL zw_req%0d: got req=%h addr=%h want 1/%h", k, imem_req, imem_addr, 16'(k)); end
      imem_ack = 1'b1; imem_rdata = 16'hC000 + 16'(k);
      tick();
      imem_ack = 1'b0;
      n_cmp++; if (inst_valid !== 1'b1 || inst_out !== (16'hC000 + 16'(k)) || pc_out !== 16'(k)) begin n_err++; $display("FAIL zw_word%0d: got v=%h ir=%h pc=%h want 1/%h/%h", k, inst_valid, inst_out, pc_out, 16'hC000 + 16'(k), 16'(k)); end
      if (pc_adv === 1'b1) adv_cnt++;
      tick();
      pc_in = 16'(k + 1);
      n_cmp++; if (inst_valid !== 1'b0 || pc_adv !== 1'b0) begin n_err++; $display("FAIL zw_idle%0d: got v=%h adv=%h want 0/0", k, inst_valid, pc_adv); end
    end
    n_cmp++; if (adv_cnt !== 4) begin n_err++; $display("FAIL zw_advcnt: got %0d want 4", adv_cnt); end
  endtask

  task automatic test_delayed_ack;
    pc_in = 16'h0040;
    tick();
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0040) begin n_err++; $display("FAIL dly_addr%0d: got req=%h addr=%h want 1/0040", i, imem_req, imem_addr); end
      if (i < 3) tick();
    end
    imem_ack = 1'b1; imem_rdata = 16'hA55A;
    tick();
    imem_ack = 1'b0;
    n_cmp++; if (inst_out !== 16'hA55A || inst_valid !== 1'b1 || pc_out !== 16'h0040) begin n_err++; $display("FAIL dly_word: got ir=%h v=%h pc=%h want A55A/1/0040", inst_out, inst_valid, pc_out); end
    n_cmp++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL dly_reqdrop: got %h want 0", imem_req); end
  endtask

  task automatic test_stall;
    stall = 1'b1;
    #1;
    n_cmp++; if (pc_adv !== 1'b0) begin n_err++; $display("FAIL stl_adv0: got %h want 0", pc_adv); end
    for (int i = 0; i < 5; i++) begin
      tick();
      n_cmp++; if (inst_out !== 16'hA55A || pc_out !== 16'h0040 || inst_valid !== 1'b1 || pc_adv !== 1'b0) begin n_err++; $display("FAIL stl_hold%0d: got ir=%h pc=%h v=%h adv=%h want A55A/0040/1/0", i, inst_out, pc_out, inst_valid, pc_adv); end
    end
    stall = 1'b0;
    #1;
    n_cmp++; if (pc_adv !== 1'b1) begin n_err++; $display("FAIL stl_release: got %h want 1", pc_adv); end
    tick();
    pc_in = 16'h0041;
    n_cmp++; if (pc_adv !== 1'b0 || inst_valid !== 1'b0) begin n_err++; $display("FAIL stl_single: got adv=%h v=%h want 0/0", pc_adv, inst_valid); end
  endtask

  task automatic test_flush_wait;
    tick();
    n_cmp++; if (imem_addr !== 16'h0041) begin n_err++; $display("FAIL flw_addr: got %h want 0041", imem_addr); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    pc_in = 16'h0080;
    n_cmp++; if (imem_req !== 1'b1 || inst_valid !== 1'b0) begin n_err++; $display("FAIL flw_pending: got req=%h v=%h want 1/0", imem_req, inst_valid); end
    tick();
    imem_ack = 1'b1; imem_rdata = 16'h1234;
    tick();
    imem_ack = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0 || inst_out !== 16'hA55A || imem_req !== 1'b0) begin n_err++; $display("FAIL flw_discard: got v=%h ir=%h req=%h want 0/A55A/0", inst_valid, inst_out, imem_req); end
    tick();
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0080) begin n_err++; $display("FAIL flw_refetch: got req=%h addr=%h want 1/0080", imem_req, imem_addr); end
    imem_ack = 1'b1; imem_rdata = 16'hBEEF;
    tick();
    imem_ack = 1'b0;
    n_cmp++; if (inst_valid !== 1'b1 || inst_out !== 16'hBEEF || pc_out !== 16'h0080) begin n_err++; $display("FAIL flw_new: got v=%h ir=%h pc=%h want 1/BEEF/0080", inst_valid, inst_out, pc_out); end
    tick();
    pc_in = 16'h0081;
  endtask

  task automatic test_flush_corners;
    tick();
    flush = 1'b1; imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    tick();
    flush = 1'b0; imem_ack = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0 || inst_out !== 16'hBEEF || imem_req !== 1'b0) begin n_err++; $display("FAIL fla_same: got v=%h ir=%h req=%h want 0/BEEF/0", inst_valid, inst_out, imem_req); end
    tick();
    imem_ack = 1'b1; imem_rdata = 16'h5555;
    tick();
    imem_ack = 1'b0;
    n_cmp++; if (inst_valid !== 1'b1 || inst_out !== 16'h5555 || pc_out !== 16'h0081) begin n_err++; $display("FAIL flh_load: got v=%h ir=%h pc=%h want 1/5555/0081", inst_valid, inst_out, pc_out); end
    stall = 1'b1; flush = 1'b1;
    #1;
    n_cmp++; if (pc_adv !== 1'b0) begin n_err++; $display("FAIL flh_adv: got %h want 0", pc_adv); end
    tick();
    stall = 1'b0; flush = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0 || pc_adv !== 1'b0) begin n_err++; $display("FAIL flh_win: got v=%h adv=%h want 0/0", inst_valid, pc_adv); end
  endtask

  task automatic test_timeout;
    tick();
    for (int i = 0; i < 14; i++) tick();
    n_cmp++; if (tmo !== 1'b0) begin n_err++; $display("FAIL tmo_early: got %h want 0", tmo); end
    tick();
    n_cmp++; if (tmo !== 1'b1 || imem_req !== 1'b1) begin n_err++; $display("FAIL tmo_set: got tmo=%h req=%h want 1/1", tmo, imem_req); end
    imem_ack = 1'b1; imem_rdata = 16'h7777;
    tick();
    imem_ack = 1'b0;
    n_cmp++; if (tmo !== 1'b1 || inst_valid !== 1'b1 || inst_out !== 16'h7777) begin n_err++; $display("FAIL tmo_sticky: got tmo=%h v=%h ir=%h want 1/1/7777", tmo, inst_valid, inst_out); end
    tick();
    tick();
    n_cmp++; if (tmo !== 1'b1 || imem_req !== 1'b1) begin n_err++; $display("FAIL tmo_keep: got tmo=%h req=%h want 1/1", tmo, imem_req); end
  endtask

  task automatic test_reset_midwait;
    #3;
    n_rst = 1'b0;
    #1;
    n_cmp++; if (imem_req !== 1'b0 || imem_addr !== 16'h0000 || inst_out !== 16'h0000 || pc_out !== 16'h0000) begin n_err++; $display("FAIL mrst_bus: got req=%h addr=%h ir=%h pc=%h want 0/0000/0000/0000", imem_req, imem_addr, inst_out, pc_out); end
    n_cmp++; if (inst_valid !== 1'b0 || pc_adv !== 1'b0 || tmo !== 1'b0) begin n_err++; $display("FAIL mrst_flags: got v=%h adv=%h tmo=%h want 0/0/0", inst_valid, pc_adv, tmo); end
    tick();
    n_rst = 1'b1;
    imem_ack = 1'b1; imem_rdata = 16'h9999;
    tick();
    imem_ack = 1'b0;
    n_cmp++; if (inst_valid !== 1'b0 || inst_out !== 16'h0000 || tmo !== 1'b0) begin n_err++; $display("FAIL mrst_late: got v=%h ir=%h tmo=%h want 0/0000/0", inst_valid, inst_out, tmo); end
    n_cmp++; if (imem_req !== 1'b1 || imem_addr !== 16'h0081) begin n_err++; $display("FAIL mrst_fresh: got req=%h addr=%h want 1/0081", imem_req, imem_addr); end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_delayed_ack();
    test_stall();
    test_flush_wait();
    test_flush_corners();
    test_timeout();
    test_reset_midwait();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/ifetch.md
IFETCH -- requirements
Module: ifetch

Interface
REQ-001 Parameter DATA_W, default 16 (from def.v); instruction and address width.
REQ-002 Parameter TMO_CYC, default 15; maximum wait cycles for imem_ack before timeout.
REQ-003 The module SHALL have one clock; reset is asynchronous and active-low, and the ports SHALL be named clock and n_rst.
REQ-004 clock  in  1  rising-edge clock.
REQ-005 n_rst  in  1  asynchronous active-low reset.
REQ-006 pc_in  in  DATA_W  current PC value from the pc block.
REQ-007 stall  in  1  consumer cannot accept inst_out this cycle.
REQ-008 flush  in  1  discard the held or in-flight instruction (branch taken).
REQ-009 imem_req  out  1  instruction memory request.
REQ-010 imem_addr  out  DATA_W  request address.
REQ-011 imem_ack  in  1  memory response valid; one-cycle pulse.
REQ-012 imem_rdata  in  DATA_W  instruction word, valid with imem_ack.
REQ-013 inst_out  out  DATA_W  fetched instruction register (IR).
REQ-014 pc_out  out  DATA_W  address that inst_out was fetched from.
REQ-015 inst_valid  out  1  inst_out/pc_out valid for the consumer.
REQ-016 pc_adv  out  1  one-cycle count enable to the pc block.
REQ-017 tmo  out  1  sticky fetch-timeout flag.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT, HOLD, all transitions registered on the rising edge of clock.
REQ-019 In IDLE, the FSM SHALL capture pc_in into addr_q, assert imem_req on the next cycle and enter WAIT.
REQ-020 In WAIT, imem_req=1, and imem_addr=addr_q SHALL stay stable until imem_ack=1.
REQ-021 On imem_ack in WAIT with no pending drop, the block SHALL set IR<=imem_rdata, pc_out<=addr_q, inst_valid<=1 and enter HOLD.
REQ-022 In HOLD with stall=0 and flush=0, the block SHALL pulse pc_adv for exactly one cycle, clear inst_valid and enter IDLE; an accepted word therefore yields one pc_adv.
REQ-023 In HOLD with stall=1, the block SHALL keep IR, pc_out and inst_valid unchanged, with pc_adv=0.
REQ-024 On flush in HOLD, the block SHALL clear inst_valid next cycle, pc_adv=0, and enter IDLE (refetch from the new pc_in).
REQ-025 On flush in WAIT, the block SHALL set a drop flag; the outstanding request SHALL still complete, and on its imem_ack the data SHALL be discarded, drop cleared and the FSM SHALL enter IDLE.
REQ-026 When flush and imem_ack occur in the same cycle in WAIT, the response SHALL be discarded (flush wins).
REQ-027 When flush and stall occur together in HOLD, flush SHALL win.
REQ-028 A wait counter SHALL clear on entry to WAIT and increment each WAIT cycle without ack, saturating at TMO_CYC; reaching TMO_CYC SHALL set tmo, which stays set until reset, and the request SHALL remain asserted.
REQ-029 No address arithmetic is performed here; pc_out is a registered copy of addr_q, DATA_W bits, and no wrap logic is needed.

Reset
REQ-030 With n_rst=0, the block SHALL immediately set state=IDLE, imem_req=0, imem_addr=0, inst_out=16'h0000 (NOP), pc_out=0, inst_valid=0, pc_adv=0, tmo=0, drop=0 and counter=0.
REQ-031 Reset asserted mid-WAIT SHALL abandon the request; a late imem_ack after reset release SHALL be ignored in IDLE.

Structure
REQ-032 DATA_W, the state encodings (IDLE/WAIT/HOLD) and the NOP constant SHALL reside in def.v.
REQ-033 The wait counter and tmo flag SHALL be a sub-module ifetch_wdt (ports clock, n_rst, clr, en, tmo); all other logic is flat.

Verification
REQ-034 Zero-wait memory (ack one cycle after req), stall=0, pc_in 0x0000..0x0003 -> inst_valid every third cycle, pc_out 0x0000,0x0001,..., and one pc_adv per instruction.
REQ-035 Ack delayed 3 cycles -> imem_addr stable for 4 cycles, inst_out=imem_rdata (e.g. 0xA55A), inst_valid=1.
REQ-036 stall=1 for 5 cycles in HOLD -> inst_out/pc_out unchanged, pc_adv=0; on release, a single pc_adv pulse.
REQ-037 flush in WAIT, then ack with 0x1234 -> inst_valid stays 0, next request addresses the new pc_in=0x0080.
REQ-038 No ack for 15 cycles -> tmo=1 and remains 1 after a later ack; n_rst=0 -> all outputs return to their reset values immediately.
